// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch
// Brief    : rv32i instruction-fetch stage. Issues one instruction-memory read
//            at a time and feeds decode from a 2-entry {pc, instr, fault} queue.
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h00000013
) (
    input  logic            clk,
    input  logic            res,
    input  logic [XLEN-1:0] pc_in,
    output logic            pc_en,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            flush,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc,
    output logic            id_fault
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [XLEN-1:0] r_tag_pc;
    logic [XLEN-1:0] r_q_pc    [2];
    logic [XLEN-1:0] r_q_instr [2];
    logic            r_q_fault [2];
    logic            r_wr_ptr;
    logic            r_rd_ptr;
    logic [1:0]      r_count;

    logic            w_misaligned;
    logic            w_slot_free;
    logic            w_room_after_pop;
    logic            w_room_after_push;
    logic            w_pop;
    logic            w_push;
    logic [XLEN-1:0] w_push_pc;
    logic [XLEN-1:0] w_push_instr;
    logic            w_push_fault;
    logic            w_take_tag;

    assign w_misaligned = |pc_in[1:0];
    assign id_valid     = (r_count != 2'd0);
    assign w_pop        = id_valid & id_ready & ~flush;
    // Nothing is outstanding in IDLE/REQ, so only the queue occupancy matters there.
    assign w_slot_free       = (r_count < 2'd2);
    assign w_room_after_pop  = w_slot_free | w_pop;
    assign w_room_after_push = (r_count == 2'd0) | w_pop;

    always_comb begin
        w_state_next = r_state;
        imem_req     = 1'b0;
        pc_en        = 1'b0;
        w_push       = 1'b0;
        w_push_pc    = r_tag_pc;
        w_push_instr = imem_rdata;
        w_push_fault = 1'b0;
        w_take_tag   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (flush || w_room_after_pop) w_state_next = S_REQ;
            end
            S_REQ: begin
                if (!w_slot_free) begin
                    if (!flush) w_state_next = S_IDLE;
                end else if (w_misaligned) begin
                    if (!flush) begin
                        w_push       = 1'b1;
                        w_push_pc    = pc_in;
                        w_push_instr = NOP_INSTR;
                        w_push_fault = 1'b1;
                        pc_en        = 1'b1;
                    end
                end else begin
                    imem_req = 1'b1;
                    if (imem_gnt) begin
                        w_take_tag = 1'b1;
                        if (flush) begin
                            w_state_next = S_DROP;
                        end else begin
                            pc_en        = 1'b1;
                            w_state_next = S_WAIT;
                        end
                    end
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    w_push       = ~flush;
                    w_state_next = (flush || w_room_after_push) ? S_REQ : S_IDLE;
                end else if (flush) begin
                    w_state_next = S_DROP;
                end
            end
            default: begin
                if (imem_rvalid) w_state_next = S_REQ;
            end
        endcase
    end

    assign imem_addr = imem_req ? pc_in : '0;
    assign id_instr  = id_valid ? r_q_instr[r_rd_ptr] : '0;
    assign id_pc     = id_valid ? r_q_pc[r_rd_ptr]    : '0;
    assign id_fault  = id_valid & r_q_fault[r_rd_ptr];

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_state  <= S_IDLE;
            r_tag_pc <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_take_tag) r_tag_pc <= pc_in;
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_count      <= 2'd0;
            r_wr_ptr     <= 1'b0;
            r_rd_ptr     <= 1'b0;
            r_q_pc[0]    <= '0;
            r_q_pc[1]    <= '0;
            r_q_instr[0] <= '0;
            r_q_instr[1] <= '0;
            r_q_fault[0] <= 1'b0;
            r_q_fault[1] <= 1'b0;
        end else if (flush) begin
            r_count  <= 2'd0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
        end else begin
            if (w_push) begin
                r_q_pc[r_wr_ptr]    <= w_push_pc;
                r_q_instr[r_wr_ptr] <= w_push_instr;
                r_q_fault[r_wr_ptr] <= w_push_fault;
                r_wr_ptr            <= ~r_wr_ptr;
            end
            if (w_pop) r_rd_ptr <= ~r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire
